// File: rtl/uart_load_ctrl.sv
// uart_load_ctrl: boot loader sequencer between the UART receiver and the
// program/data memory. Packs received bytes into 32-bit words, writes them to
// consecutive word addresses from 0, holds the CPU while a load is running and
// reports done / error status once the load ends.
module uart_load_ctrl #(
    parameter int ADDR_W      = 14,
    parameter int MAX_WORDS   = 16384,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              load_en,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_cnt
);

    // The idle timer only has to reach TIMEOUT_CYC-1, so it needs clog2(TIMEOUT_CYC) bits.
    localparam int              TMR_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W:0]  CNT_MAX  = (ADDR_W + 1)'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [1:0]          r_byteIdx;
    logic [31:0]         r_word;
    logic [TMR_W-1:0]    r_timer;
    logic [ADDR_W:0]     r_wordCnt;
    logic                r_memWe;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [31:0]         r_memWdata;
    logic                r_cpuHold;
    logic                r_loadDone;
    logic                r_loadErr;

    logic [1:0]          w_lane;
    logic [31:0]         w_wordNext;
    logic [ADDR_W:0]     w_newCnt;
    logic                w_startLoad;
    logic                w_acceptByte;
    logic                w_commit;
    logic                w_timerClr;
    logic                w_timerInc;

    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign cpu_hold  = r_cpuHold;
    assign load_done = r_loadDone;
    assign load_err  = r_loadErr;
    assign word_cnt  = r_wordCnt;

    assign w_newCnt  = r_wordCnt + {{ADDR_W{1'b0}}, 1'b1};

    // Word being assembled with the incoming byte dropped into its lane; the lane
    // order reverses between big- and little-endian packing.
    always_comb begin
        w_lane     = BIG_ENDIAN ? (2'd3 - r_byteIdx) : r_byteIdx;
        w_wordNext = r_word;
        w_wordNext[{w_lane, 3'b000} +: 8] = rx_data;
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the per-cycle datapath controls; dropping load_en
    // always wins so an abort never produces a further write.
    always_comb begin
        w_nextState  = r_state;
        w_startLoad  = 1'b0;
        w_acceptByte = 1'b0;
        w_commit     = 1'b0;
        w_timerClr   = 1'b0;
        w_timerInc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_en) begin
                    w_nextState = ST_RECV;
                    w_startLoad = 1'b1;
                end
            end
            ST_RECV: begin
                if (!load_en) begin
                    w_nextState = ST_IDLE;
                end else if (rx_done) begin
                    w_acceptByte = 1'b1;
                    if (r_byteIdx == 2'd3) begin
                        w_nextState = ST_WRITE;
                        w_commit    = 1'b1;
                    end
                end else if ((r_byteIdx == 2'd0) && (r_wordCnt == '0)) begin
                    w_timerClr = 1'b1;
                end else if (r_timer == TMR_LAST) begin
                    w_nextState = (r_byteIdx != 2'd0) ? ST_ERROR : ST_DONE;
                end else begin
                    w_timerInc = 1'b1;
                end
            end
            ST_WRITE: begin
                if (!load_en) begin
                    w_nextState = ST_IDLE;
                end else if (w_newCnt == CNT_MAX) begin
                    w_nextState = ST_DONE;
                end else begin
                    w_nextState = ST_RECV;
                    if (rx_done) begin
                        w_acceptByte = 1'b1;
                    end else begin
                        w_timerInc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!load_en) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (!load_en) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; status flags follow the state being entered
    // so they line up with the state register on the same edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_byteIdx  <= 2'd0;
            r_word     <= 32'd0;
            r_timer    <= '0;
            r_wordCnt  <= '0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= 32'd0;
            r_cpuHold  <= 1'b0;
            r_loadDone <= 1'b0;
            r_loadErr  <= 1'b0;
        end else begin
            r_memWe <= 1'b0;
            if (w_startLoad) begin
                r_wordCnt  <= '0;
                r_byteIdx  <= 2'd0;
                r_timer    <= '0;
                r_loadDone <= 1'b0;
                r_loadErr  <= 1'b0;
            end
            if (w_acceptByte) begin
                r_word    <= w_wordNext;
                r_byteIdx <= r_byteIdx + 2'd1;
                r_timer   <= '0;
            end
            if (w_timerClr) begin
                r_timer <= '0;
            end
            if (w_timerInc) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_commit) begin
                r_memWe    <= 1'b1;
                r_memAddr  <= r_wordCnt[ADDR_W-1:0];
                r_memWdata <= w_wordNext;
            end
            if (r_state == ST_WRITE) begin
                r_wordCnt <= w_newCnt;
            end
            if (w_nextState == ST_DONE) begin
                r_loadDone <= 1'b1;
            end
            if (w_nextState == ST_ERROR) begin
                r_loadErr <= 1'b1;
            end
            r_cpuHold <= (w_nextState == ST_RECV) || (w_nextState == ST_WRITE) ||
                         (w_nextState == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_uart_load_ctrl.sv
// tb_uart_load_ctrl: three loader instances (big-endian, little-endian, and a
// 4-word memory) share one byte stream; results are compared with a
// transaction-level model of what a load of N bytes should produce.
module tb_uart_load_ctrl;

   localparam int TMO = 100;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        load_en;
   logic        rx_done;
   logic [7:0]  rx_data;

   logic        weA, weB, weC;
   logic [13:0] addrA, addrB, addrC;
   logic [31:0] wdA, wdB, wdC;
   logic        holdA, holdB, holdC;
   logic        doneA, doneB, doneC;
   logic        errA, errB, errC;
   logic [14:0] cntA, cntB, cntC;

   int cmpCount = 0;
   int failCount = 0;

   logic [45:0] qA[$];
   logic [45:0] qB[$];
   logic [45:0] qC[$];
   logic [7:0]  seq[$];

   typedef struct {
      int           nBytes;
      logic [135:0] bytes;
      int           silence;
      logic         expDoneA;
      logic         expErrA;
      int           expCntA;
      logic [31:0]  expWord0A;
      logic [31:0]  expWord0B;
      logic         expDoneC;
      int           expCntC;
   } vec_t;

   vec_t vecs[6];

   always #5 sys_clk = ~sys_clk;

   uart_load_ctrl #(.ADDR_W(14), .MAX_WORDS(16384), .TIMEOUT_CYC(TMO), .BIG_ENDIAN(1'b1)) dutA (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .load_en(load_en), .rx_done(rx_done),
      .rx_data(rx_data), .mem_we(weA), .mem_addr(addrA), .mem_wdata(wdA), .cpu_hold(holdA),
      .load_done(doneA), .load_err(errA), .word_cnt(cntA));

   uart_load_ctrl #(.ADDR_W(14), .MAX_WORDS(16384), .TIMEOUT_CYC(TMO), .BIG_ENDIAN(1'b0)) dutB (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .load_en(load_en), .rx_done(rx_done),
      .rx_data(rx_data), .mem_we(weB), .mem_addr(addrB), .mem_wdata(wdB), .cpu_hold(holdB),
      .load_done(doneB), .load_err(errB), .word_cnt(cntB));

   uart_load_ctrl #(.ADDR_W(14), .MAX_WORDS(4), .TIMEOUT_CYC(TMO), .BIG_ENDIAN(1'b1)) dutC (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .load_en(load_en), .rx_done(rx_done),
      .rx_data(rx_data), .mem_we(weC), .mem_addr(addrC), .mem_wdata(wdC), .cpu_hold(holdC),
      .load_done(doneC), .load_err(errC), .word_cnt(cntC));

   // Record every memory write of each instance, sampled mid-cycle.
   always @(negedge sys_clk) begin
      if (weA) qA.push_back({addrA, wdA});
      if (weB) qB.push_back({addrB, wdB});
      if (weC) qC.push_back({addrC, wdC});
   end

   // Keep the run bounded even if something stalls.
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      cmpCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic gap(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      @(negedge sys_clk);
      rx_done = 1'b1;
      rx_data = b;
      @(negedge sys_clk);
      rx_done = 1'b0;
   endtask

   task automatic startLoad();
      @(negedge sys_clk);
      load_en = 1'b0;
      gap(3);
      qA.delete();
      qB.delete();
      qC.delete();
      load_en = 1'b1;
      gap(2);
   endtask

   function automatic int maxOf(input int d);
      return (d == 2) ? 4 : 16384;
   endfunction

   function automatic bit beOf(input int d);
      return (d != 1);
   endfunction

   // {cpu_hold, load_done, load_err, word_cnt}
   function automatic logic [17:0] statusOf(input int d);
      case (d)
         0:       return {holdA, doneA, errA, cntA};
         1:       return {holdB, doneB, errB, cntB};
         default: return {holdC, doneC, errC, cntC};
      endcase
   endfunction

   function automatic int wrSize(input int d);
      case (d)
         0:       return qA.size();
         1:       return qB.size();
         default: return qC.size();
      endcase
   endfunction

   function automatic logic [45:0] wrAt(input int d, input int k);
      case (d)
         0:       return qA[k];
         1:       return qB[k];
         default: return qC[k];
      endcase
   endfunction

   // Expected word k of the byte stream: four consecutive bytes in arrival order.
   function automatic logic [31:0] modelWord(input int k, input bit be);
      logic [7:0] b0, b1, b2, b3;
      b0 = seq[4*k];
      b1 = seq[4*k+1];
      b2 = seq[4*k+2];
      b3 = seq[4*k+3];
      return be ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
   endfunction

   // Outcome of a load of n bytes followed by silence: full memory ends it cleanly,
   // otherwise a leftover partial word is an error and whole words alone are done.
   task automatic modelLoad(input int n, input int maxW, output logic eDone, output logic eErr,
                            output int eCnt);
      int whole;
      whole = n / 4;
      eDone = 1'b0;
      eErr  = 1'b0;
      if (whole >= maxW) begin
         eCnt  = maxW;
         eDone = 1'b1;
      end else begin
         eCnt = whole;
         if ((n % 4) != 0) eErr = 1'b1;
         else if (n > 0)   eDone = 1'b1;
      end
   endtask

   // Send seq, wait out the silence, compare every instance with the model, then release.
   task automatic runLoad(input string tag, input int silence, input bit randGaps);
      logic        eDone[3];
      logic        eErr[3];
      int          eCnt[3];
      logic [17:0] st;
      logic [45:0] wr;
      int          n;
      n = seq.size();
      startLoad();
      for (int i = 0; i < n; i++) begin
         applyStimulus(seq[i]);
         gap(randGaps ? int'($urandom_range(20, 60)) : 25);
      end
      gap(silence);
      for (int d = 0; d < 3; d++) begin
         modelLoad(n, maxOf(d), eDone[d], eErr[d], eCnt[d]);
         st = statusOf(d);
         checkOutput($sformatf("%s_d%0d_done", tag, d), 64'(st[16]), 64'(eDone[d]));
         checkOutput($sformatf("%s_d%0d_err", tag, d), 64'(st[15]), 64'(eErr[d]));
         checkOutput($sformatf("%s_d%0d_cnt", tag, d), 64'(st[14:0]), 64'(eCnt[d]));
         checkOutput($sformatf("%s_d%0d_hold", tag, d), 64'(st[17]), 64'(!eDone[d]));
         checkOutput($sformatf("%s_d%0d_nwr", tag, d), 64'(wrSize(d)), 64'(eCnt[d]));
         for (int k = 0; k < wrSize(d) && k < eCnt[d]; k++) begin
            wr = wrAt(d, k);
            checkOutput($sformatf("%s_d%0d_addr%0d", tag, d, k), 64'(wr[45:32]), 64'(k));
            checkOutput($sformatf("%s_d%0d_data%0d", tag, d, k), 64'(wr[31:0]),
                        64'(modelWord(k, beOf(d))));
         end
      end
      load_en = 1'b0;
      gap(2);
      for (int d = 0; d < 3; d++) begin
         st = statusOf(d);
         checkOutput($sformatf("%s_d%0d_hold_off", tag, d), 64'(st[17]), 64'd0);
         checkOutput($sformatf("%s_d%0d_done_kept", tag, d), 64'(st[16]), 64'(eDone[d]));
      end
   endtask

   initial begin
      logic [135:0] tmp;
      logic [45:0]  wr;

      vecs[0] = '{8,  {64'h123456789ABCDEF0, 72'h0}, 150, 1'b1, 1'b0, 2,
                  32'h12345678, 32'h78563412, 1'b1, 2};
      vecs[1] = '{4,  {32'h12345678, 104'h0}, 150, 1'b1, 1'b0, 1,
                  32'h12345678, 32'h78563412, 1'b1, 1};
      vecs[2] = '{2,  {16'hAABB, 120'h0}, 150, 1'b0, 1'b1, 0,
                  32'h0, 32'h0, 1'b0, 0};
      vecs[3] = '{0,  136'h0, 500, 1'b0, 1'b0, 0,
                  32'h0, 32'h0, 1'b0, 0};
      vecs[4] = '{17, 136'h0102030405060708090A0B0C0D0E0F1011, 150, 1'b0, 1'b1, 4,
                  32'h01020304, 32'h04030201, 1'b1, 4};
      vecs[5] = '{6,  {48'hC0FFEE123456, 88'h0}, 150, 1'b0, 1'b1, 1,
                  32'hC0FFEE12, 32'h12EEFFC0, 1'b0, 1};

      sys_rst_n = 1'b0;
      load_en   = 1'b0;
      rx_done   = 1'b0;
      rx_data   = 8'h00;
      gap(3);
      checkOutput("reset_we", 64'(weA), 64'd0);
      checkOutput("reset_addr", 64'(addrA), 64'd0);
      checkOutput("reset_wdata", 64'(wdA), 64'd0);
      checkOutput("reset_status", 64'(statusOf(0)), 64'd0);
      sys_rst_n = 1'b1;
      gap(2);

      // Table-driven loads.
      for (int v = 0; v < 6; v++) begin
         seq.delete();
         tmp = vecs[v].bytes;
         for (int i = 0; i < vecs[v].nBytes; i++) seq.push_back(tmp[135-8*i -: 8]);
         runLoad($sformatf("vec%0d", v), vecs[v].silence, 1'b0);
         checkOutput($sformatf("vec%0d_tbl_doneA", v), 64'(doneA), 64'(vecs[v].expDoneA));
         checkOutput($sformatf("vec%0d_tbl_errA", v), 64'(errA), 64'(vecs[v].expErrA));
         checkOutput($sformatf("vec%0d_tbl_cntA", v), 64'(cntA), 64'(vecs[v].expCntA));
         checkOutput($sformatf("vec%0d_tbl_doneC", v), 64'(doneC), 64'(vecs[v].expDoneC));
         checkOutput($sformatf("vec%0d_tbl_cntC", v), 64'(cntC), 64'(vecs[v].expCntC));
         if (vecs[v].expCntA > 0) begin
            checkOutput($sformatf("vec%0d_tbl_nwrA", v), 64'(qA.size() > 0), 64'd1);
            checkOutput($sformatf("vec%0d_tbl_nwrB", v), 64'(qB.size() > 0), 64'd1);
            if (qA.size() > 0) checkOutput($sformatf("vec%0d_tbl_w0A", v), 64'(qA[0][31:0]),
                                           64'(vecs[v].expWord0A));
            if (qB.size() > 0) checkOutput($sformatf("vec%0d_tbl_w0B", v), 64'(qB[0][31:0]),
                                           64'(vecs[v].expWord0B));
         end
      end

      // Randomized loads against the model.
      for (int r = 0; r < 6; r++) begin
         seq.delete();
         for (int i = 0; i < int'($urandom_range(0, 18)); i++) seq.push_back(8'($urandom_range(0, 255)));
         runLoad($sformatf("rnd%0d", r), 150, 1'b1);
      end

      // Write latency, and a byte arriving during the write cycle.
      startLoad();
      applyStimulus(8'h11); gap(20);
      applyStimulus(8'h22); gap(20);
      applyStimulus(8'h33); gap(20);
      rx_done = 1'b1;
      rx_data = 8'h44;
      checkOutput("lat_we_early", 64'(weA), 64'd0);
      @(posedge sys_clk); #1;
      rx_done = 1'b0;
      checkOutput("lat_we", 64'(weA), 64'd1);
      checkOutput("lat_addr", 64'(addrA), 64'd0);
      checkOutput("lat_wdata", 64'(wdA), 64'h11223344);
      rx_done = 1'b1;
      rx_data = 8'h55;
      @(posedge sys_clk); #1;
      rx_done = 1'b0;
      checkOutput("lat_we_pulse", 64'(weA), 64'd0);
      checkOutput("lat_cnt", 64'(cntA), 64'd1);
      gap(20);
      applyStimulus(8'h66); gap(20);
      applyStimulus(8'h77); gap(20);
      applyStimulus(8'h88); gap(150);
      checkOutput("wrbyte_nwrA", 64'(qA.size()), 64'd2);
      if (qA.size() == 2) begin
         wr = qA[1];
         checkOutput("wrbyte_addr1", 64'(wr[45:32]), 64'd1);
         checkOutput("wrbyte_dataA1", 64'(wr[31:0]), 64'h55667788);
      end
      if (qB.size() == 2) checkOutput("wrbyte_dataB1", 64'(qB[1][31:0]), 64'h88776655);
      else checkOutput("wrbyte_nwrB", 64'(qB.size()), 64'd2);
      checkOutput("wrbyte_done", 64'(doneA), 64'd1);
      checkOutput("wrbyte_cnt", 64'(cntA), 64'd2);

      // Abort after three bytes, then reload from address 0.
      startLoad();
      applyStimulus(8'hA1); gap(20);
      applyStimulus(8'hA2); gap(20);
      applyStimulus(8'hA3); gap(20);
      load_en = 1'b0;
      @(posedge sys_clk); #1;
      checkOutput("abort_hold", 64'(holdA), 64'd0);
      gap(3);
      checkOutput("abort_nwr", 64'(qA.size()), 64'd0);
      load_en = 1'b1;
      gap(2);
      applyStimulus(8'hAB); gap(20);
      applyStimulus(8'hCD); gap(20);
      applyStimulus(8'hEF); gap(20);
      applyStimulus(8'h01); gap(5);
      checkOutput("reload_nwr", 64'(qA.size()), 64'd1);
      if (qA.size() == 1) checkOutput("reload_wr", 64'(qA[0]), 64'({14'd0, 32'hABCDEF01}));
      checkOutput("reload_cnt", 64'(cntA), 64'd1);

      // load_en dropped in the same cycle as the fourth byte: no write.
      startLoad();
      applyStimulus(8'hB1); gap(20);
      applyStimulus(8'hB2); gap(20);
      applyStimulus(8'hB3); gap(20);
      rx_done = 1'b1;
      rx_data = 8'hB4;
      load_en = 1'b0;
      @(negedge sys_clk);
      rx_done = 1'b0;
      gap(3);
      checkOutput("lastbyte_abort_nwr", 64'(qA.size()), 64'd0);
      checkOutput("lastbyte_abort_cnt", 64'(cntA), 64'd0);
      checkOutput("lastbyte_abort_hold", 64'(holdA), 64'd0);

      // Asynchronous reset in the middle of a write.
      startLoad();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(8'(8'hC0 + i));
         gap(20);
      end
      rx_done = 1'b1;
      rx_data = 8'hC7;
      @(posedge sys_clk); #1;
      rx_done = 1'b0;
      checkOutput("rst_pre_we", 64'(weA), 64'd1);
      checkOutput("rst_pre_addr", 64'(addrA), 64'd1);
      #1;
      sys_rst_n = 1'b0;
      #1;
      checkOutput("rst_we", 64'(weA), 64'd0);
      checkOutput("rst_addr", 64'(addrA), 64'd0);
      checkOutput("rst_wdata", 64'(wdA), 64'd0);
      checkOutput("rst_status", 64'(statusOf(0)), 64'd0);
      load_en = 1'b0;
      gap(2);
      sys_rst_n = 1'b1;
      gap(2);

      $display("End of test - %0d assertions evaluated, %0d failures", cmpCount, failCount);
      $finish;
   end

endmodule
